// File: rtl/sequ_serializer_pkg.sv
// Shared types for the serializer and the downstream sequence detector.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sequ_serializer_if.sv
// Word-in / bit-out bundle between stimulus source and serializer.
interface sequ_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             enable;
    logic             data_out;
    logic             bit_valid;
    logic             word_start;
    logic             busy;

    modport master (
        output din, din_valid, enable,
        input  din_ready, data_out, bit_valid, word_start, busy
    );

    modport slave (
        input  din, din_valid, enable,
        output din_ready, data_out, bit_valid, word_start, busy
    );
endinterface

// File: rtl/sequ_serializer_hold_buf.sv
// One-entry valid/ready holding register in front of the shifter.
module ser_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_pop
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;
    logic             accept;

    // Ready depends only on occupancy, so a pop and a push never collide.
    always_comb begin
        accept = in_valid & ~full_q;
        full_d = accept | (full_q & ~out_pop);
        data_d = accept ? in : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign in_ready  = ~full_q;
    assign out       = data_q;
    assign out_valid = full_q;
endmodule

// File: rtl/sequ_serializer.sv
// Parallel-to-serial bit source with zero-gap word streaming.
module sequ_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input logic               clk,
    input logic               rst,
    sequ_serializer_if.slave  bus
);
    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             bv_q, bv_d;
    logic             ws_q, ws_d;

    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             hold_pop;

    ser_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .in       (bus.din),
        .in_valid (bus.din_valid),
        .in_ready (bus.din_ready),
        .out      (hold_data),
        .out_valid(hold_full),
        .out_pop  (hold_pop)
    );

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        bv_d     = 1'b0;
        ws_d     = 1'b0;
        hold_pop = 1'b0;
        case (state_q)
            IDLE: begin
                dout_d = IDLE_LEVEL;
                if (hold_full) begin
                    hold_pop = 1'b1;
                    state_d  = SHIFT;
                    sh_d     = hold_data;
                    cnt_d    = '0;
                    dout_d   = head(hold_data);
                    bv_d     = 1'b1;
                    ws_d     = 1'b1;
                end
            end
            SHIFT: begin
                // A paused cycle keeps every register and only drops bit_valid.
                if (bus.enable) begin
                    if (cnt_q == LAST) begin
                        if (hold_full) begin
                            hold_pop = 1'b1;
                            sh_d     = hold_data;
                            cnt_d    = '0;
                            dout_d   = head(hold_data);
                            bv_d     = 1'b1;
                            ws_d     = 1'b1;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            dout_d  = IDLE_LEVEL;
                        end
                    end else begin
                        sh_d   = adv(sh_q);
                        cnt_d  = cnt_q + CW'(1);
                        dout_d = head(adv(sh_q));
                        bv_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= IDLE_LEVEL;
            bv_q    <= 1'b0;
            ws_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            bv_q    <= bv_d;
            ws_q    <= ws_d;
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.bit_valid  = bv_q;
    assign bus.word_start = ws_q;
    assign bus.busy       = hold_full | (state_q == SHIFT);
endmodule

// File: tb/tb_sequ_serializer.sv
// Directed bench for sequ_serializer: MSB-first and LSB-first instances.
module tb_sequ_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sequ_serializer_if #(.WIDTH(8)) bus_m ();
    sequ_serializer_if #(.WIDTH(8)) bus_l ();

    sequ_serializer #(
        .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus_m)
    );

    sequ_serializer #(
        .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
    ) dut_lsb (
        .clk(clk), .rst(rst), .bus(bus_l)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_m.din = 8'hE8;
        bus_m.din_valid = 1'b1;
        bus_m.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus_m.din_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_ready cyc %0d got %b want 1", i, bus_m.din_ready);
            end
            checks++;
            if (bus_m.bit_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_bv cyc %0d got %b want 0", i, bus_m.bit_valid);
            end
            checks++;
            if (bus_m.data_out !== 1'b0) begin
                errors++;
                $display("FAIL rst_dout cyc %0d got %b want 0", i, bus_m.data_out);
            end
            checks++;
            if (bus_m.busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_busy cyc %0d got %b want 0", i, bus_m.busy);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus_m.din_ready !== 1'b1 || bus_m.busy !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_idle got ready=%b busy=%b want 1 0",
                     bus_m.din_ready, bus_m.busy);
        end
        step();
        checks++;
        if (bus_m.din_ready !== 1'b0 || bus_m.busy !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_accept got ready=%b busy=%b want 0 1",
                     bus_m.din_ready, bus_m.busy);
        end
        bus_m.din_valid = 1'b0;
        repeat (12) step();
        checks++;
        if (bus_m.busy !== 1'b0 || bus_m.bit_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle got busy=%b bv=%b want 0 0",
                     bus_m.busy, bus_m.bit_valid);
        end
    endtask

    task automatic test_single(input string tag);
        logic [7:0] w;
        w = 8'hE8;
        bus_m.din = w;
        bus_m.din_valid = 1'b1;
        step();
        checks++;
        if (bus_m.din_ready !== 1'b0 || bus_m.bit_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept got ready=%b bv=%b want 0 0",
                     tag, bus_m.din_ready, bus_m.bit_valid);
        end
        bus_m.din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (bus_m.bit_valid !== 1'b1 || bus_m.data_out !== w[7-i]) begin
                errors++;
                $display("FAIL %s_bit%0d got bv=%b d=%b want 1 %b",
                         tag, i, bus_m.bit_valid, bus_m.data_out, w[7-i]);
            end
            checks++;
            if (bus_m.word_start !== (i == 0)) begin
                errors++;
                $display("FAIL %s_ws%0d got %b want %b",
                         tag, i, bus_m.word_start, (i == 0));
            end
        end
        step();
        checks++;
        if (bus_m.bit_valid !== 1'b0 || bus_m.data_out !== 1'b0
            || bus_m.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_end got bv=%b d=%b busy=%b want 0 0 0",
                     tag, bus_m.bit_valid, bus_m.data_out, bus_m.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        p = 16'hF40F;
        bus_m.din = 8'hF4;
        bus_m.din_valid = 1'b1;
        step();
        checks++;
        if (bus_m.din_ready !== 1'b0 || bus_m.bit_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept1 got ready=%b bv=%b want 0 0",
                     bus_m.din_ready, bus_m.bit_valid);
        end
        bus_m.din = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (bus_m.bit_valid !== 1'b1 || bus_m.data_out !== p[15-i]) begin
                errors++;
                $display("FAIL b2b_bit%0d got bv=%b d=%b want 1 %b",
                         i, bus_m.bit_valid, bus_m.data_out, p[15-i]);
            end
            checks++;
            if (bus_m.word_start !== (i == 0 || i == 8)) begin
                errors++;
                $display("FAIL b2b_ws%0d got %b want %b",
                         i, bus_m.word_start, (i == 0 || i == 8));
            end
            if (i == 0) begin
                checks++;
                if (bus_m.din_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready_drain got %b want 1", bus_m.din_ready);
                end
            end
            if (i == 1) begin
                checks++;
                if (bus_m.din_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ready_acc2 got %b want 0", bus_m.din_ready);
                end
                bus_m.din_valid = 1'b0;
            end
        end
        step();
        checks++;
        if (bus_m.bit_valid !== 1'b0 || bus_m.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got bv=%b busy=%b want 0 0",
                     bus_m.bit_valid, bus_m.busy);
        end
    endtask

    task automatic test_pause();
        logic [7:0] p;
        p = 8'hA5;
        bus_m.din = p;
        bus_m.din_valid = 1'b1;
        step();
        bus_m.din_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus_m.bit_valid !== 1'b1 || bus_m.data_out !== p[7-i]) begin
                errors++;
                $display("FAIL pause_pre%0d got bv=%b d=%b want 1 %b",
                         i, bus_m.bit_valid, bus_m.data_out, p[7-i]);
            end
        end
        bus_m.enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus_m.bit_valid !== 1'b0 || bus_m.data_out !== p[5]
                || bus_m.busy !== 1'b1) begin
                errors++;
                $display("FAIL pause_hold%0d got bv=%b d=%b busy=%b want 0 %b 1",
                         k, bus_m.bit_valid, bus_m.data_out, bus_m.busy, p[5]);
            end
        end
        bus_m.enable = 1'b1;
        for (int i = 3; i < 8; i++) begin
            step();
            checks++;
            if (bus_m.bit_valid !== 1'b1 || bus_m.data_out !== p[7-i]
                || bus_m.word_start !== 1'b0) begin
                errors++;
                $display("FAIL pause_post%0d got bv=%b d=%b ws=%b want 1 %b 0",
                         i, bus_m.bit_valid, bus_m.data_out,
                         bus_m.word_start, p[7-i]);
            end
        end
        step();
        checks++;
        if (bus_m.bit_valid !== 1'b0) begin
            errors++;
            $display("FAIL pause_end got bv=%b want 0", bus_m.bit_valid);
        end
    endtask

    task automatic test_lsb_first();
        bus_l.din = 8'h01;
        bus_l.din_valid = 1'b1;
        step();
        bus_l.din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (bus_l.bit_valid !== 1'b1 || bus_l.data_out !== (i == 0)) begin
                errors++;
                $display("FAIL lsb_bit%0d got bv=%b d=%b want 1 %b",
                         i, bus_l.bit_valid, bus_l.data_out, (i == 0));
            end
        end
        step();
        checks++;
        if (bus_l.bit_valid !== 1'b0 || bus_l.busy !== 1'b0) begin
            errors++;
            $display("FAIL lsb_end got bv=%b busy=%b want 0 0",
                     bus_l.bit_valid, bus_l.busy);
        end
    endtask

    task automatic test_reset_mid_word();
        bus_m.din = 8'hFF;
        bus_m.din_valid = 1'b1;
        step();
        bus_m.din_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus_m.bit_valid !== 1'b1 || bus_m.data_out !== 1'b1) begin
                errors++;
                $display("FAIL mid_bit%0d got bv=%b d=%b want 1 1",
                         i, bus_m.bit_valid, bus_m.data_out);
            end
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus_m.data_out !== 1'b0 || bus_m.bit_valid !== 1'b0
            || bus_m.busy !== 1'b0 || bus_m.din_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst got d=%b bv=%b busy=%b ready=%b want 0 0 0 1",
                     bus_m.data_out, bus_m.bit_valid, bus_m.busy, bus_m.din_ready);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus_m.bit_valid !== 1'b0 || bus_m.data_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_residual got bv=%b d=%b want 0 0",
                     bus_m.bit_valid, bus_m.data_out);
        end
        test_single("after_rst");
    endtask

    initial begin
        bus_m.din = '0;
        bus_m.din_valid = 1'b0;
        bus_m.enable = 1'b1;
        bus_l.din = '0;
        bus_l.din_valid = 1'b0;
        bus_l.enable = 1'b1;
        test_reset();
        test_single("single");
        test_back_to_back();
        test_pause();
        test_lsb_first();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
